rv_alu_decode_stage: RTL and testbench
======================================

// Module: rv_alu_decode_stage
// PURPOSE
// - Registered decode stage that drives the RV32I ALU: turns a fetched instruction into the 4-bit ALU control code plus operand/writeback controls.
// - Sits between fetch and the ALU/branch-resolve logic. Valid/ready on both sides; a 2-entry skid buffer gives full throughput under backpressure.
// PARAMETERS
// - XLEN  32  datapath width of pc and immediate outputs
// PORTS
// - clk          in   1     single clock, rising edge
// - rst_n        in   1     asynchronous active-low reset
// - in_valid     in   1     instruction present on in_instr/in_pc
// - in_ready     out  1     stage can accept an instruction this cycle
// - in_instr     in   32    raw RV32I instruction word
// - in_pc        in   XLEN  instruction address
// - out_valid    out  1     decoded bundle valid
// - out_ready    in   1     downstream accepts the bundle
// - out_alu_ctrl out  4     ALU operation code (table below)
// - out_use_imm  out  1     ALU operand b = out_imm (else rs2)
// - out_imm      out  XLEN  sign-extended immediate (I/S/B/U format)
// - out_rs1/out_rs2/out_rd  out  5 each  register indices (rs1 forced to 0 for LUI)
// - out_reg_write out 1     result is written to rd (forced 0 when rd==0)
// - out_is_branch out 1     ALU Comparison output decides the branch
// - out_pc       out  XLEN  pc passed through with the bundle
// BEHAVIOUR
// - Reset (async): both buffer entries invalid. out_valid=0, in_ready=1. All data outputs 0.
// - Transfers: an input transfer happens when in_valid&&in_ready. An output transfer happens when out_valid&&out_ready.
// - Latency: 1 cycle (in at edge N -> out_valid at edge N+1). Throughput is 1 per cycle while out_ready=1.
// - Skid buffer: main register plus skid register. in_ready is registered and equals !skid_valid.
//   - Input accepted while out_valid && !out_ready: captured into skid.
//   - When main drains, skid moves to main.
//   - Simultaneous input and output transfer with skid empty: main is reloaded.
//   - No bundle is dropped or duplicated. Output data is stable while out_valid && !out_ready.
// - ALU codes: AND 0000, OR 0001, ADD 0010, SLTU 0011, SLT 0100, BLTU 0101, SUB 0110, BGEU 0111.
//   SLL 1000, XOR 1001, SRL 1010, SRA 1011, BEQ 1100, BNE 1101, BLT 1110, BGE 1111.
// - Decode by opcode:
//   - 0110011 R-type: funct3 + funct7[5]; SUB/SRA use funct7=0100000. use_imm=0, reg_write=1.
//   - 0010011 I-ALU: funct3. SRAI uses imm[11:5]=0100000; ADDI never yields SUB. Shift amount comes from imm[4:0]. use_imm=1, reg_write=1.
//   - 0000011 LOAD / 0100011 STORE: ADD, use_imm=1. reg_write is 1 for LOAD and 0 for STORE.
//   - 1100011 BRANCH: funct3 000/001/100/101/110/111 -> BEQ/BNE/BLT/BGE/BLTU/BGEU. is_branch=1, use_imm=0, reg_write=0. out_imm = B-immediate.
//   - 0110111 LUI: ADD, rs1=0, use_imm=1, imm={instr[31:12],12'b0}.
//   - Anything else, or BRANCH funct3 010/011: illegal. Code ADD, reg_write=0, is_branch=0.
// CONFIGURATION
// - Macro RV_DECODE_ILLEGAL_FLAG_EN.
//   - Defined: adds output port out_illegal (1 bit), carried with the bundle and set for every illegal case above. Also adds an 8-bit saturating counter out_illegal_cnt, which increments on each output transfer with out_illegal=1 and resets to 0.
//   - Undefined: neither port exists. Illegal instructions pass silently as ADD no-ops.
// STRUCTURE
// - Package rv_alu_pkg holds:
//   - typedef enum logic [3:0] alu_ctrl_e with the codes above;
//   - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI);
//   - struct dec_bundle_t holding all out_* fields.
// - Sub-module rv_instr_decoder: purely combinational instr -> dec_bundle_t.
// - This module contains only the skid buffer and handshake.
// TESTING
// - Case 1: add x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle alu_ctrl=0010, rd=3, rs1=1, rs2=2, use_imm=0, reg_write=1.
// - Case 2: sub 0x402081B3 -> alu_ctrl=0110. srai x5,x6,4 (0x40435293) -> alu_ctrl=1011, use_imm=1, imm=0x404, rd=5.
// - Case 3: beq x1,x2,+8 (0x00208463) -> alu_ctrl=1100, is_branch=1, imm=8, reg_write=0. Same word with funct3=110 -> alu_ctrl=0101.
// - Case 4: stream 4 instrs with in_valid=1 and out_ready held 0 for 3 cycles.
//   - in_ready drops after 2 accepted.
//   - out data is stable while stalled.
//   - After release, all 4 emerge in order, one per cycle.
// - Case 5: assert rst_n low mid-stream (async, between edges) -> out_valid=0 and in_ready=1 immediately; first instr after release decodes correctly.
// - Case 6: with RV_DECODE_ILLEGAL_FLAG_EN, send 0x0000000B (custom-0) -> out_illegal=1, alu_ctrl=0010, reg_write=0, out_illegal_cnt 0->1.

Source files
------------

// File: rtl/rv_alu_decode_stage_pkg.sv
// Shared types for the RV32I ALU decode stage: ALU codes, opcodes and the decoded bundle.
// Optional field `illegal` exists only when RV_DECODE_ILLEGAL_FLAG_EN is defined.
package rv_alu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ILEN     = 32;
    localparam int unsigned REG_IDXW = 5;
    localparam int unsigned CNT_W    = 8;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_SLT  = 4'b0100,
        ALU_BLTU = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_BGEU = 4'b0111,
        ALU_SLL  = 4'b1000,
        ALU_XOR  = 4'b1001,
        ALU_SRL  = 4'b1010,
        ALU_SRA  = 4'b1011,
        ALU_BEQ  = 4'b1100,
        ALU_BNE  = 4'b1101,
        ALU_BLT  = 4'b1110,
        ALU_BGE  = 4'b1111
    } alu_ctrl_e;

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     imm;
        alu_ctrl_e           alu_ctrl;
        logic                use_imm;
        logic [REG_IDXW-1:0] rs1;
        logic [REG_IDXW-1:0] rs2;
        logic [REG_IDXW-1:0] rd;
        logic                reg_write;
        logic                is_branch;
`ifdef RV_DECODE_ILLEGAL_FLAG_EN
        logic                illegal;
`endif
    } dec_bundle_t;

    // Shared R-type / I-ALU mapping; alt selects SUB/SRA where funct3 allows it.
    function automatic alu_ctrl_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_ctrl_e code;
        code = ALU_ADD;
        case (funct3)
            3'b000:  code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/rv_alu_decode_stage_if.sv
// Fetch-side and ALU-side valid/ready bus of the decode stage.
// out_illegal / out_illegal_cnt exist only when RV_DECODE_ILLEGAL_FLAG_EN is defined.
interface rv_alu_decode_stage_if;
    import rv_alu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [ILEN-1:0]     in_instr;
    logic [XLEN-1:0]     in_pc;

    logic                out_valid;
    logic                out_ready;
    logic [3:0]          out_alu_ctrl;
    logic                out_use_imm;
    logic [XLEN-1:0]     out_imm;
    logic [REG_IDXW-1:0] out_rs1;
    logic [REG_IDXW-1:0] out_rs2;
    logic [REG_IDXW-1:0] out_rd;
    logic                out_reg_write;
    logic                out_is_branch;
    logic [XLEN-1:0]     out_pc;
`ifdef RV_DECODE_ILLEGAL_FLAG_EN
    logic                out_illegal;
    logic [CNT_W-1:0]    out_illegal_cnt;
`endif

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_alu_ctrl, out_use_imm, out_imm,
               out_rs1, out_rs2, out_rd, out_reg_write, out_is_branch, out_pc
`ifdef RV_DECODE_ILLEGAL_FLAG_EN
        , input out_illegal, out_illegal_cnt
`endif
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_alu_ctrl, out_use_imm, out_imm,
               out_rs1, out_rs2, out_rd, out_reg_write, out_is_branch, out_pc
`ifdef RV_DECODE_ILLEGAL_FLAG_EN
        , output out_illegal, out_illegal_cnt
`endif
    );

endinterface

// File: rtl/rv_instr_decoder.sv
// Purely combinational RV32I instruction -> ALU control bundle decoder.
// Sets the bundle's illegal field when RV_DECODE_ILLEGAL_FLAG_EN is defined.
module rv_instr_decoder
    import rv_alu_pkg::*;
(
    input  logic [ILEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output dec_bundle_t     dec_o
);

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [REG_IDXW-1:0] rd;
    logic [REG_IDXW-1:0] rs1;
    logic [REG_IDXW-1:0] rs2;
    logic [XLEN-1:0]     imm_i;
    logic [XLEN-1:0]     imm_s;
    logic [XLEN-1:0]     imm_b;
    logic [XLEN-1:0]     imm_u;
    logic                illegal;
    logic                writes_rd;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};

    always_comb begin
        dec_o          = '0;
        dec_o.pc       = pc_i;
        dec_o.alu_ctrl = ALU_ADD;
        dec_o.rs1      = rs1;
        dec_o.rs2      = rs2;
        dec_o.rd       = rd;
        illegal        = 1'b0;
        writes_rd      = 1'b0;

        case (opcode)
            OP_R: begin
                dec_o.alu_ctrl = alu_from_funct3(funct3, instr_i[30]);
                writes_rd      = 1'b1;
            end
            OP_IMM: begin
                // Only the shift group honours bit 30, so ADDI can never become SUB.
                dec_o.alu_ctrl = alu_from_funct3(funct3, (funct3 == 3'b101) && instr_i[30]);
                dec_o.use_imm  = 1'b1;
                dec_o.imm      = imm_i;
                writes_rd      = 1'b1;
            end
            OP_LOAD: begin
                dec_o.use_imm = 1'b1;
                dec_o.imm     = imm_i;
                writes_rd     = 1'b1;
            end
            OP_STORE: begin
                dec_o.use_imm = 1'b1;
                dec_o.imm     = imm_s;
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000:  dec_o.alu_ctrl = ALU_BEQ;
                    3'b001:  dec_o.alu_ctrl = ALU_BNE;
                    3'b100:  dec_o.alu_ctrl = ALU_BLT;
                    3'b101:  dec_o.alu_ctrl = ALU_BGE;
                    3'b110:  dec_o.alu_ctrl = ALU_BLTU;
                    3'b111:  dec_o.alu_ctrl = ALU_BGEU;
                    default: illegal        = 1'b1;
                endcase
                dec_o.is_branch = ~illegal;
                dec_o.imm       = illegal ? '0 : imm_b;
            end
            OP_LUI: begin
                dec_o.rs1     = '0;
                dec_o.use_imm = 1'b1;
                dec_o.imm     = imm_u;
                writes_rd     = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        dec_o.reg_write = writes_rd && (rd != '0);
`ifdef RV_DECODE_ILLEGAL_FLAG_EN
        dec_o.illegal   = illegal;
`endif
    end

endmodule

// File: rtl/rv_alu_decode_stage.sv
// Registered RV32I decode stage: main + skid register pair giving full throughput under backpressure.
// Optional illegal flag and saturating illegal counter via RV_DECODE_ILLEGAL_FLAG_EN.
module rv_alu_decode_stage
    import rv_alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    rv_alu_decode_stage_if.slave bus
);

    dec_bundle_t dec_c;
    dec_bundle_t main_q, main_d;
    dec_bundle_t skid_q, skid_d;
    logic        main_valid_q, main_valid_d;
    logic        skid_valid_q, skid_valid_d;
    logic        in_fire;
    logic        out_fire;

    rv_instr_decoder u_decoder (
        .instr_i (bus.in_instr),
        .pc_i    (bus.in_pc),
        .dec_o   (dec_c)
    );

    assign in_fire  = bus.in_valid & ~skid_valid_q;
    assign out_fire = main_valid_q & bus.out_ready;

    // Main refills from skid first so ordering is preserved; skid only catches a stalled accept.
    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;

        if (out_fire || !main_valid_q) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_valid_d = 1'b1;
                main_d       = dec_c;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_d       = dec_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign bus.in_ready      = ~skid_valid_q;
    assign bus.out_valid     = main_valid_q;
    assign bus.out_alu_ctrl  = main_q.alu_ctrl;
    assign bus.out_use_imm   = main_q.use_imm;
    assign bus.out_imm       = main_q.imm;
    assign bus.out_rs1       = main_q.rs1;
    assign bus.out_rs2       = main_q.rs2;
    assign bus.out_rd        = main_q.rd;
    assign bus.out_reg_write = main_q.reg_write;
    assign bus.out_is_branch = main_q.is_branch;
    assign bus.out_pc        = main_q.pc;

`ifdef RV_DECODE_ILLEGAL_FLAG_EN
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (out_fire && main_q.illegal && (illegal_cnt_q != {CNT_W{1'b1}})) begin
            illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt_q <= '0;
        end else begin
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign bus.out_illegal     = main_q.illegal;
    assign bus.out_illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_rv_alu_decode_stage.sv
// Randomised + directed bench for rv_alu_decode_stage against an occupancy/queue reference model.
// Also checks the illegal flag and counter when RV_DECODE_ILLEGAL_FLAG_EN is defined.
module tb_rv_alu_decode_stage;

    typedef struct {
        logic [3:0]  alu;
        logic        use_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        is_branch;
        logic        illegal;
        logic [31:0] pc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   cnt_exp;
    exp_t q[$];

    rv_alu_decode_stage_if bus ();

    rv_alu_decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference decode written straight from the ISA field layout and the code table.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t               e;
        logic [3:0]         r_tab[16];
        logic [3:0]         b_tab[8];
        logic signed [31:0] sw;
        logic [31:0]        imm_i;
        logic [2:0]         f3;
        logic               wr;
        r_tab = '{4'b0010, 4'b1000, 4'b0100, 4'b0011, 4'b1001, 4'b1010, 4'b0001, 4'b0000,
                  4'b0110, 4'b1000, 4'b0100, 4'b0011, 4'b1001, 4'b1011, 4'b0001, 4'b0000};
        b_tab = '{4'b1100, 4'b1101, 4'b0010, 4'b0010, 4'b1110, 4'b1111, 4'b0101, 4'b0111};
        sw    = w;
        imm_i = 32'(sw >>> 20);
        f3    = w[14:12];
        wr    = 1'b0;
        e.alu = 4'b0010; e.use_imm = 1'b0; e.imm = 32'd0;
        e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
        e.is_branch = 1'b0; e.illegal = 1'b0; e.pc = pc;
        case (w[6:0])
            7'b0110011: begin e.alu = r_tab[{w[30], f3}]; wr = 1'b1; end
            7'b0010011: begin
                e.alu = r_tab[{w[30] && (f3 == 3'd5), f3}];
                e.use_imm = 1'b1; e.imm = imm_i; wr = 1'b1;
            end
            7'b0000011: begin e.use_imm = 1'b1; e.imm = imm_i; wr = 1'b1; end
            7'b0100011: begin
                e.use_imm = 1'b1;
                e.imm = (imm_i & 32'hFFFF_FFE0) | 32'(w[11:7]);
            end
            7'b1100011: begin
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    e.illegal = 1'b1;
                end else begin
                    e.alu = b_tab[f3];
                    e.is_branch = 1'b1;
                    e.imm = (32'(sw >>> 19) & 32'hFFFF_F000) | (32'(w[7]) << 11)
                          | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
                end
            end
            7'b0110111: begin
                e.rs1 = 5'd0; e.use_imm = 1'b1; e.imm = w & 32'hFFFF_F000; wr = 1'b1;
            end
            default: e.illegal = 1'b1;
        endcase
        e.reg_write = wr && (w[11:7] != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  op;
        w = $urandom;
        case ($urandom_range(0, 8))
            0: op = 7'b0110011;
            1: op = 7'b0010011;
            2: op = 7'b0000011;
            3: op = 7'b0100011;
            4: op = 7'b1100011;
            5: op = 7'b0110111;
            6: op = 7'b0001011;
            7: op = 7'b0110011;
            default: op = w[6:0];
        endcase
        return {w[31:7], op};
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'(q.size() > 0));
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            check({tag, "_alu"},       32'(bus.out_alu_ctrl),  32'(q[0].alu));
            check({tag, "_use_imm"},   32'(bus.out_use_imm),   32'(q[0].use_imm));
            check({tag, "_imm"},       bus.out_imm,            q[0].imm);
            check({tag, "_rs1"},       32'(bus.out_rs1),       32'(q[0].rs1));
            check({tag, "_rs2"},       32'(bus.out_rs2),       32'(q[0].rs2));
            check({tag, "_rd"},        32'(bus.out_rd),        32'(q[0].rd));
            check({tag, "_reg_write"}, 32'(bus.out_reg_write), 32'(q[0].reg_write));
            check({tag, "_is_branch"}, 32'(bus.out_is_branch), 32'(q[0].is_branch));
            check({tag, "_pc"},        bus.out_pc,             q[0].pc);
`ifdef RV_DECODE_ILLEGAL_FLAG_EN
            check({tag, "_illegal"},   32'(bus.out_illegal),   32'(q[0].illegal));
`endif
        end
`ifdef RV_DECODE_ILLEGAL_FLAG_EN
        check({tag, "_illegal_cnt"}, 32'(bus.out_illegal_cnt), 32'(cnt_exp));
`endif
    endtask

    // Called at a falling edge: drive, let one rising edge pass, update model, check at next falling edge.
    task automatic step(input string tag, input logic v, input logic [31:0] w,
                        input logic [31:0] pc, input logic rdy, output logic acc);
        logic fin;
        logic fout;
        exp_t e;
        bus.in_valid  = v;
        bus.in_instr  = w;
        bus.in_pc     = pc;
        bus.out_ready = rdy;
        fin  = v && (q.size() < 2);
        fout = rdy && (q.size() > 0);
        e    = ref_decode(w, pc);
        @(posedge clk);
        if (fout) begin
            if (q[0].illegal && cnt_exp < 255) cnt_exp++;
            void'(q.pop_front());
        end
        if (fin) q.push_back(e);
        acc = fin;
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        logic        acc;
        logic [31:0] stream[4];
        int          idx;
        n_checks = 0;
        n_errors = 0;
        cnt_exp  = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.in_pc     = 32'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_alu",       32'(bus.out_alu_ctrl), 32'd0);
        check("rst_imm",       bus.out_imm, 32'd0);
        check("rst_pc",        bus.out_pc,  32'd0);
        rst_n = 1'b1;

        step("c1_add", 1'b1, 32'h002081B3, 32'h0000_1000, 1'b1, acc);
        check("c1_alu_const", 32'(bus.out_alu_ctrl), 32'h2);
        check("c1_rd_const",  32'(bus.out_rd), 32'd3);
        check("c1_rs1_const", 32'(bus.out_rs1), 32'd1);
        check("c1_rs2_const", 32'(bus.out_rs2), 32'd2);
        check("c1_wr_const",  32'(bus.out_reg_write), 32'd1);
        check("c1_imm_const", 32'(bus.out_use_imm), 32'd0);

        step("c2_sub", 1'b1, 32'h402081B3, 32'h0000_1004, 1'b1, acc);
        check("c2_sub_alu_const", 32'(bus.out_alu_ctrl), 32'h6);
        step("c2_srai", 1'b1, 32'h40435293, 32'h0000_1008, 1'b1, acc);
        check("c2_srai_alu_const", 32'(bus.out_alu_ctrl), 32'hB);
        check("c2_srai_imm_const", bus.out_imm, 32'h404);
        check("c2_srai_use_const", 32'(bus.out_use_imm), 32'd1);
        check("c2_srai_rd_const",  32'(bus.out_rd), 32'd5);

        step("c3_beq", 1'b1, 32'h00208463, 32'h0000_100C, 1'b1, acc);
        check("c3_beq_alu_const", 32'(bus.out_alu_ctrl), 32'hC);
        check("c3_beq_br_const",  32'(bus.out_is_branch), 32'd1);
        check("c3_beq_imm_const", bus.out_imm, 32'd8);
        check("c3_beq_wr_const",  32'(bus.out_reg_write), 32'd0);
        step("c3_bltu", 1'b1, 32'h0020E463, 32'h0000_1010, 1'b1, acc);
        check("c3_bltu_alu_const", 32'(bus.out_alu_ctrl), 32'h5);
        step("c3_drain", 1'b0, 32'd0, 32'd0, 1'b1, acc);

        // Backpressure: four back-to-back instructions, output stalled for three cycles.
        stream[0] = 32'h002081B3; stream[1] = 32'h40435293;
        stream[2] = 32'h00208463; stream[3] = 32'h12345037;
        idx = 0;
        for (int c = 0; c < 3; c++) begin
            step("c4_stall", 1'b1, stream[idx], 32'h2000 + 32'(idx * 4), 1'b0, acc);
            if (acc) idx++;
        end
        check("c4_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("c4_accepted", 32'(idx), 32'd2);
        for (int c = 0; c < 12 && q.size() > 0; c++) begin
            step("c4_release", idx < 4, stream[idx % 4], 32'h2000 + 32'(idx * 4), 1'b1, acc);
            if (acc) idx++;
        end
        check("c4_all_accepted", 32'(idx), 32'd4);
        check("c4_drained", 32'(q.size()), 32'd0);

        // Async reset landing between clock edges with two bundles in flight.
        step("c5_fill", 1'b1, 32'h00500093, 32'h3000, 1'b0, acc);
        step("c5_fill", 1'b1, 32'h00A00113, 32'h3004, 1'b0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        check("c5_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("c5_rst_in_ready",  32'(bus.in_ready),  32'd1);
        q.delete();
        cnt_exp = 0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step("c5_after", 1'b1, 32'h002081B3, 32'h3008, 1'b1, acc);
        check("c5_after_alu_const", 32'(bus.out_alu_ctrl), 32'h2);

`ifdef RV_DECODE_ILLEGAL_FLAG_EN
        step("c6_custom", 1'b1, 32'h0000000B, 32'h4000, 1'b1, acc);
        check("c6_illegal_const", 32'(bus.out_illegal), 32'd1);
        check("c6_alu_const",     32'(bus.out_alu_ctrl), 32'h2);
        check("c6_wr_const",      32'(bus.out_reg_write), 32'd0);
        check("c6_cnt0_const",    32'(bus.out_illegal_cnt), 32'd0);
        step("c6_drain", 1'b0, 32'd0, 32'd0, 1'b1, acc);
        check("c6_cnt1_const",    32'(bus.out_illegal_cnt), 32'd1);
`endif

        for (int c = 0; c < 600; c++) begin
            step("rnd", $urandom_range(0, 9) < 7, rand_instr(), {$urandom_range(0, 65535), 2'b00},
                 $urandom_range(0, 9) < 6, acc);
        end
        for (int c = 0; c < 8 && q.size() > 0; c++) begin
            step("final_drain", 1'b0, 32'd0, 32'd0, 1'b1, acc);
        end
        check("final_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
